// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Optional lock feature is selected with the DMEM_ARB_LOCK_EN macro.
package dmem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int DMEM_ADDR_W = 5;
    localparam int DMEM_DATA_W = 8;
    localparam int MAX_REQ     = 4;

    // Behavioural round-robin pick: first set bit of valid at or after ptr,
    // wrapping modulo n (n <= MAX_REQ). Returns 0 when nothing is valid.
    function automatic logic [1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [1:0]         ptr,
                                           input int                 n);
        logic [1:0] r_pick;
        logic       found;
        int         idx;
        r_pick = '0;
        found  = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && valid[idx[1:0]]) begin
                found  = 1'b1;
                r_pick = idx[1:0];
            end
        end
        return r_pick;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
// The req_lock vector exists only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
`ifdef DMEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]             req_lock;
`endif
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_rdata;

    // Requesters side
    modport master (
`ifdef DMEM_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Arbiter side
    modport slave (
`ifdef DMEM_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so that ptr
// sits at bit 0, priority-encode the lowest set bit, then unrotate the index.
module rr_picker #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);
    logic [N-1:0]  w_rot;
    logic [PW-1:0] w_enc;
    logic          w_found;
    logic [PW:0]   w_sum;
    logic [PW:0]   w_wrap;

    // w_rot[gi] = i_valid[(ptr + gi) mod N]
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [PW:0] w_src;
            logic [PW:0] w_src_wrap;
            assign w_src      = {1'b0, i_ptr} + (PW+1)'(gi);
            assign w_src_wrap = (w_src >= (PW+1)'(N)) ? (w_src - (PW+1)'(N)) : w_src;
            assign w_rot[gi]  = i_valid[w_src_wrap[PW-1:0]];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the closest requester after ptr
    always_comb begin
        w_enc   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_enc   = PW'(k);
            end
        end
    end

    assign w_sum    = {1'b0, i_ptr} + {1'b0, w_enc};
    assign w_wrap   = (w_sum >= (PW+1)'(N)) ? (w_sum - (PW+1)'(N)) : w_sum;
    assign o_idx    = w_wrap[PW-1:0];
    assign o_any    = w_found;
    assign o_onehot = w_found ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory (combinational read,
// posedge write) among NUM_REQ requesters; one access per cycle, read data
// returned one cycle after the grant.
// Define DMEM_ARB_LOCK_EN to let a requester hold the grant for up to
// MAX_LOCK consecutive accesses (MAX_LOCK >= 2).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 2,
    parameter  int ADDR_W   = DMEM_ADDR_W,
    parameter  int DATA_W   = DMEM_DATA_W,
    parameter  int MAX_LOCK = 4,
    localparam int PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    dmem_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0]  o_mem_read_addr,
    input  logic [DATA_W-1:0]  i_mem_read_data,
    output logic               o_mem_write_enable,
    output logic [ADDR_W-1:0]  o_mem_write_addr,
    output logic [DATA_W-1:0]  o_mem_write_data
);
    logic [PW-1:0]      r_rr_ptr;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_onehot;
    logic [PW-1:0]      w_idx;
    logic               w_grant;
    logic               w_gnt_we;
    logic [PW:0]        w_ptr_inc;
    logic [PW-1:0]      w_ptr_next;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_e         r_state, w_state_next;
    logic [PW-1:0]      r_owner, w_owner_next;
    logic [CW-1:0]      r_lock_cnt, w_lock_cnt_next;

    // While locked only the owner is eligible
    assign w_mask = (r_state == LOCK) ? (NUM_REQ'(1) << r_owner) : '1;

    // Lock FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_lock_cnt <= w_lock_cnt_next;
        end
    end

    // Lock FSM next state; lock_cnt counts grants held including the first,
    // so the grant that brings it to MAX_LOCK releases the lock.
    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_lock_cnt_next = r_lock_cnt;
        case (r_state)
            ARB: begin
                if (w_grant && bus.req_lock[w_idx]) begin
                    w_state_next    = LOCK;
                    w_owner_next    = w_idx;
                    w_lock_cnt_next = CW'(1);
                end
            end
            LOCK: begin
                if (w_grant) begin
                    if (!bus.req_lock[w_idx] || r_lock_cnt == CW'(MAX_LOCK - 1)) begin
                        w_state_next    = ARB;
                        w_lock_cnt_next = '0;
                    end else begin
                        w_lock_cnt_next = r_lock_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_next    = ARB;
                w_lock_cnt_next = '0;
            end
        endcase
    end
`else
    assign w_mask = '1;
`endif

    // No grant (and therefore no write) while reset is held
    assign w_elig = bus.req_valid & w_mask & {NUM_REQ{~rst}};

    rr_picker #(.N(NUM_REQ)) u_picker (
        .i_valid  (w_elig),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_grant)
    );

    assign w_gnt_we   = w_grant & bus.req_we[w_idx];
    assign w_ptr_inc  = {1'b0, w_idx} + (PW+1)'(1);
    assign w_ptr_next = (w_ptr_inc >= (PW+1)'(NUM_REQ)) ? '0 : w_ptr_inc[PW-1:0];

    assign bus.req_ready      = w_onehot;
    assign o_mem_read_addr    = w_grant ? bus.req_addr[w_idx]  : '0;
    assign o_mem_write_addr   = w_grant ? bus.req_addr[w_idx]  : '0;
    assign o_mem_write_data   = w_grant ? bus.req_wdata[w_idx] : '0;
    assign o_mem_write_enable = w_gnt_we;

    // Round-robin pointer moves past the winner on every grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    // One-cycle response: grantee one-hot plus captured read data (0 for writes)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_onehot;
            r_rsp_rdata <= (w_grant && !w_gnt_we) ? i_mem_read_data : '0;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by a random phase, all
// checked against a behavioural model (round-robin scan, shadow memory).
module tb_dmem_arbiter;
    localparam int NR       = 2;
    localparam int AW       = 5;
    localparam int DW       = 8;
    localparam int MAX_LOCK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [AW-1:0] mem_read_addr;
    logic [DW-1:0] mem_read_data;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;

    dmem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .o_mem_read_addr    (mem_read_addr),
        .i_mem_read_data    (mem_read_data),
        .o_mem_write_enable (mem_write_enable),
        .o_mem_write_addr   (mem_write_addr),
        .o_mem_write_data   (mem_write_data)
    );

    // DataMem: combinational read, posedge write
    logic [DW-1:0] mem [0:31] = '{default: 8'h00};
    assign mem_read_data = mem[mem_read_addr];
    always @(posedge clk) if (mem_write_enable) mem[mem_write_addr] <= mem_write_data;

    // Reference model state
    logic [DW-1:0] ref_mem [0:31] = '{default: 8'h00};
    int  m_ptr = 0;
    bit  m_locked = 0;
    int  m_owner = 0;
    int  m_cnt = 0;
    int  last_grant = -1;
    int  compared = 0;
    int  mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0; last_grant = -1;
    endtask

    task automatic drive(input int i, input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit lk);
        bus.req_valid[i] = v;
        bus.req_we[i]    = we;
        bus.req_addr[i]  = a;
        bus.req_wdata[i] = d;
`ifdef DMEM_ARB_LOCK_EN
        bus.req_lock[i]  = lk;
`else
        if (lk) begin end
`endif
    endtask

    // One clock of arbitration: inputs already applied after the negedge.
    task automatic step(input string tag);
        int g;
        logic [NR-1:0] exp_rv;
        logic [DW-1:0] exp_rd;
        bit lk;
        #1;
        g = -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (g < 0 && bus.req_valid[i] && (!m_locked || i == m_owner)) g = i;
        end
        check({tag, ".ready"}, 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check({tag, ".wen"}, 32'(mem_write_enable), (g >= 0 && bus.req_we[g]) ? 32'd1 : 32'd0);
        check({tag, ".raddr"}, 32'(mem_read_addr), (g >= 0) ? 32'(bus.req_addr[g]) : 32'd0);
        if (g >= 0 && bus.req_we[g]) begin
            check({tag, ".waddr"}, 32'(mem_write_addr), 32'(bus.req_addr[g]));
            check({tag, ".wdata"}, 32'(mem_write_data), 32'(bus.req_wdata[g]));
        end
        exp_rv = '0;
        exp_rd = '0;
        lk = 0;
        if (g >= 0) begin
            exp_rv = NR'(1) << g;
            if (bus.req_we[g]) ref_mem[bus.req_addr[g]] = bus.req_wdata[g];
            else               exp_rd = ref_mem[bus.req_addr[g]];
            m_ptr = (g + 1) % NR;
`ifdef DMEM_ARB_LOCK_EN
            lk = bus.req_lock[g];
`endif
            if (!m_locked) begin
                if (lk) begin m_locked = 1; m_owner = g; m_cnt = 1; end
            end else begin
                m_cnt++;
                if (!lk || m_cnt == MAX_LOCK) m_locked = 0;
            end
        end
        last_grant = g;
        @(posedge clk);
        #1;
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_rv));
        check({tag, ".rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pend [NR];
        int gseq [6];
        int exp_seq [6];
        exp_seq = '{0, 0, 0, 0, 1, 0};

        // 1. Reset with both requesters asking to write
        for (int i = 0; i < NR; i++) drive(i, 1, 1, 5'd1, 8'hFF, 0);
        @(negedge clk);
        @(negedge clk);
        check("reset.ready", 32'(bus.req_ready), 32'd0);
        check("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset.rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("reset.wen", 32'(mem_write_enable), 32'd0);
        model_reset();
        for (int i = 0; i < NR; i++) drive(i, 0, 0, '0, '0, 0);
        rst = 1'b0;

        // Preload mem[3]=11 via req0, mem[7]=22 via req1 (pointer returns to 0)
        drive(0, 1, 1, 5'd3, 8'h11, 0);
        step("pre0");
        drive(0, 0, 0, '0, '0, 0);
        drive(1, 1, 1, 5'd7, 8'h22, 0);
        step("pre1");

        // 2. Both reading, held valid: alternate grants, data one cycle behind
        drive(0, 1, 0, 5'd3, 8'h00, 0);
        drive(1, 1, 0, 5'd7, 8'h00, 0);
        for (int k = 0; k < 4; k++) begin
            step("alt");
            check("alt.grant", 32'(last_grant), 32'(k % 2));
            check("alt.data", 32'(bus.rsp_rdata), (k % 2 == 0) ? 32'h11 : 32'h22);
        end

        // 3. Write then read-after-write from the other requester
        drive(0, 1, 1, 5'd5, 8'hA5, 0);
        drive(1, 0, 0, '0, '0, 0);
        step("raw.w");
        drive(0, 0, 0, '0, '0, 0);
        drive(1, 1, 0, 5'd5, 8'h00, 0);
        step("raw.r");
        check("raw.rsp_valid", 32'(bus.rsp_valid), 32'h2);
        check("raw.rsp_rdata", 32'(bus.rsp_rdata), 32'hA5);

        // 4. Only req1 valid, pointer at 0: granted every cycle
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 5'(k), 8'h00, 0);
            step("solo");
            check("solo.grant", 32'(last_grant), 32'd1);
        end

        // 6. Reset right after a read grant: response lost, no write under reset
        drive(1, 0, 0, '0, '0, 0);
        drive(0, 1, 0, 5'd3, 8'h00, 0);
        #1;
        check("rstmid.ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        rst = 1'b1;
        drive(0, 1, 1, 5'd9, 8'h5A, 0);
        #1;
        check("rstmid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstmid.wen", 32'(mem_write_enable), 32'd0);
        check("rstmid.ready", 32'(bus.req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 0, 5'd3, 8'h00, 0);
        drive(1, 1, 0, 5'd7, 8'h00, 0);
        step("rstmid.after");
        check("rstmid.restart", 32'(last_grant), 32'd0);

`ifdef DMEM_ARB_LOCK_EN
        // 5. req0 locks; forced release after MAX_LOCK grants
        do_reset();
        drive(0, 1, 0, 5'd3, 8'h00, 1);
        drive(1, 1, 0, 5'd7, 8'h00, 0);
        for (int k = 0; k < 6; k++) begin
            step("lock");
            gseq[k] = last_grant;
        end
        for (int k = 0; k < 6; k++) check($sformatf("lock.seq%0d", k), 32'(gseq[k]), 32'(exp_seq[k]));
`else
        gseq = exp_seq;
        if (gseq[0] != 0) $display("note: lock sequence table unexpected");
`endif

        // Random phase: requesters hold each access until accepted
        for (int i = 0; i < NR; i++) begin
            pend[i] = 0;
            drive(i, 0, 0, '0, '0, 0);
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        pend[i] = 1;
                        drive(i, 1, bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                              8'($urandom), ($urandom_range(0, 3) == 0));
                    end else begin
                        drive(i, 0, 0, '0, '0, 0);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 0;
                    drive(i, 0, 0, '0, '0, 0);
                end
            end
            step("rand");
            if (last_grant >= 0) pend[last_grant] = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
